// File: rtl/alu_issue_if.sv
// alu_issue_if
//   Bundles the upstream (instruction + operands) and downstream (decoded ALU
//   command) handshakes of the ALU issue stage, plus the illegal-op status.
//   master : the environment side (drives instructions, accepts commands)
//   slave  : the issue stage itself
//   Parameters: DW operand width, IW instruction width, CW illegal counter width.
interface alu_issue_if #(
  parameter int DW = 8,
  parameter int IW = 9,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_cls;
  logic [1:0]    out_op;
  logic          out_use_carry;
  logic [2:0]    out_shamt;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          illegal_pulse;
  logic [CW-1:0] illegal_cnt;

  modport master (
    output in_valid, in_instr, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_cls, out_op, out_use_carry, out_shamt,
           out_a, out_b, illegal_pulse, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_a, in_b, out_ready,
    output in_ready, out_valid, out_cls, out_op, out_use_carry, out_shamt,
           out_a, out_b, illegal_pulse, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decodes one instruction per upstream handshake into an ALU command and
//   presents it, registered, on a valid/ready interface. Storage is a head
//   (output) register plus one skid register, so in_ready is a pure register
//   and never depends combinationally on out_ready. Illegal major opcodes are
//   consumed, dropped, pulsed on illegal_pulse and counted (saturating).
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - alu_issue_if.slave: in_* upstream, out_* downstream, illegal_*
module alu_issue_stage #(
  parameter int DW = 8,
  parameter int IW = 9,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  // Stored entry: {cls[1:0], op[1:0], use_carry, shamt[2:0], a, b}
  localparam int EW = 8 + 2 * DW;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [2:0] kAorC = 3'b000;
  localparam logic [2:0] kSL   = 3'b011;
  localparam logic [2:0] kSR   = 3'b100;
  localparam logic [2:0] kSRO  = 3'b101;

  logic [1:0]    state_r, stateNext_s;
  logic [EW-1:0] head_r, headNext_s;
  logic [EW-1:0] skid_r, skidNext_s;
  logic [EW-1:0] decEntry_s;
  logic [1:0]    decCls_s, decOp_s;
  logic          decUc_s, decLegal_s;
  logic [2:0]    decShamt_s;
  logic          inReady_r, outValid_r, illPulse_r;
  logic [CW-1:0] illCnt_r;
  logic          accept_s, legalAcc_s, illAcc_s, pop_s;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    decLegal_s = 1'b1;
    decCls_s   = 2'd0;
    decOp_s    = 2'd0;
    decUc_s    = 1'b0;
    decShamt_s = 3'd0;
    case (bus.in_instr[IW-1:IW-3])
      kAorC: begin
        decOp_s = bus.in_instr[IW-4:IW-5];
        decUc_s = bus.in_instr[IW-6];
      end
      kSL: begin
        decCls_s   = 2'd1;
        decShamt_s = bus.in_instr[2:0];
      end
      kSR: begin
        decCls_s   = 2'd2;
        decShamt_s = bus.in_instr[2:0];
      end
      kSRO: begin
        decCls_s   = 2'd3;
        decShamt_s = bus.in_instr[2:0];
      end
      default: decLegal_s = 1'b0;
    endcase
    decEntry_s = {decCls_s, decOp_s, decUc_s, decShamt_s, bus.in_a, bus.in_b};
  end

  // An illegal word still completes its handshake; it just never enters storage.
  assign accept_s   = bus.in_valid & inReady_r;
  assign legalAcc_s = accept_s & decLegal_s;
  assign illAcc_s   = accept_s & ~decLegal_s;
  assign pop_s      = outValid_r & bus.out_ready;

  // Occupancy and head/skid data movement.
  always_comb begin
    stateNext_s = state_r;
    headNext_s  = head_r;
    skidNext_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (legalAcc_s) begin
          stateNext_s = ONE;
          headNext_s  = decEntry_s;
        end else begin
          stateNext_s = EMPTY;
        end
      end
      ONE: begin
        if (legalAcc_s && pop_s) begin
          headNext_s = decEntry_s;         // replace head, no bubble
        end else if (legalAcc_s) begin
          stateNext_s = FULL;
          skidNext_s  = decEntry_s;
        end else if (pop_s) begin
          stateNext_s = EMPTY;
        end else begin
          stateNext_s = ONE;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop_s) begin
          stateNext_s = ONE;
          headNext_s  = skid_r;
        end else begin
          stateNext_s = FULL;
        end
      end
      default: stateNext_s = EMPTY;
    endcase
  end

  // State, data and status registers; handshake flags precomputed from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      head_r     <= {EW{1'b0}};
      skid_r     <= {EW{1'b0}};
      inReady_r  <= 1'b1;
      outValid_r <= 1'b0;
      illPulse_r <= 1'b0;
      illCnt_r   <= {CW{1'b0}};
    end else begin
      state_r    <= stateNext_s;
      head_r     <= headNext_s;
      skid_r     <= skidNext_s;
      inReady_r  <= (stateNext_s != FULL);
      outValid_r <= (stateNext_s != EMPTY);
      illPulse_r <= illAcc_s;
      if (illAcc_s && (illCnt_r != {CW{1'b1}})) begin
        illCnt_r <= illCnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        illCnt_r <= illCnt_r;
      end
    end
  end

  assign bus.in_ready      = inReady_r;
  assign bus.out_valid     = outValid_r;
  assign bus.out_cls       = head_r[EW-1:EW-2];
  assign bus.out_op        = head_r[EW-3:EW-4];
  assign bus.out_use_carry = head_r[EW-5];
  assign bus.out_shamt     = head_r[EW-6:EW-8];
  assign bus.out_a         = head_r[2*DW-1:DW];
  assign bus.out_b         = head_r[DW-1:0];
  assign bus.illegal_pulse = illPulse_r;
  assign bus.illegal_cnt   = illCnt_r;
endmodule
